rr_req_client_ctrl: RTL and testbench

- Requester-side front end for the 4-way round-robin arbiter (req/gnt one-hot interface).
- Accepts burst jobs from N local clients and raises `req[i]`.
- Waits for `gnt[i]`, then drives `beat[i]` for `len` cycles while holding `req[i]`. Releases `req[i]` and pulses `done[i]` when the burst completes.
- Sits between client logic and the arbiter. Also reports protocol errors such as grant loss, spurious grant and multi-hot grant.

---
 rtl/rr_req_pkg.sv | 21 ++
 rtl/rr_req_client.sv | 127 ++++++++++++
 rtl/rr_req_client_ctrl.sv | 79 +++++++
 tb/tb_rr_req_client_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rr_req_pkg.sv
// Shared types and defaults for the round-robin requester front end:
// client state encoding, default sizes and a grant-vector sanity helper.
package rr_req_pkg;

   localparam int N_DEF       = 4;
   localparam int LW_DEF      = 4;
   localparam int TIMEOUT_DEF = 15;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      BURST = 2'd2,
      DONE  = 2'd3
   } state_t;

   // True when at most one bit of v is set.
   function automatic logic onehot0(input logic [31:0] v);
      return ((v & (v - 32'd1)) == 32'd0);
   endfunction

endpackage

// File: rtl/rr_req_client.sv
// Single-client requester: IDLE -> REQ -> BURST -> DONE with a burst-length
// counter, plus an optional REQ wait counter (RR_REQ_TIMEOUT_EN).
module rr_req_client
   import rr_req_pkg::*;
#(
   parameter int LW = LW_DEF
`ifdef RR_REQ_TIMEOUT_EN
   , parameter int TIMEOUT = TIMEOUT_DEF
`endif
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          job_valid,
   input  logic [LW-1:0] job_len,
   input  logic          gnt,
   output logic          job_ready,
   output logic          req,
   output logic          beat,
   output logic          done,
   output logic          burst_next,
   output logic          prot_err,
   output logic          starve
);

   localparam logic [LW-1:0] CNT_ONE = {{(LW-1){1'b0}}, 1'b1};

   state_t        state_r, state_s;
   logic [LW-1:0] cnt_r, cnt_s;

   // Next-state, counter update and per-client protocol violation.
   always_comb begin
      state_s  = state_r;
      cnt_s    = cnt_r;
      prot_err = 1'b0;
      case (state_r)
         IDLE: begin
            prot_err = gnt;
            if (job_valid) begin
               state_s = REQ;
               cnt_s   = (job_len == {LW{1'b0}}) ? CNT_ONE : job_len;
            end else begin
               state_s = IDLE;
            end
         end
         REQ: begin
            if (gnt) state_s = BURST;
            else     state_s = REQ;
         end
         BURST: begin
            cnt_s = cnt_r - CNT_ONE;
            if (!gnt) begin
               // grant withdrawn mid-burst: drop the remaining beats
               prot_err = 1'b1;
               state_s  = DONE;
               cnt_s    = {LW{1'b0}};
            end else if (cnt_r == CNT_ONE) begin
               state_s = DONE;
            end else begin
               state_s = BURST;
            end
         end
         DONE: begin
            prot_err = gnt;
            state_s  = IDLE;
         end
         default: begin
            state_s = IDLE;
            cnt_s   = {LW{1'b0}};
         end
      endcase
   end

   assign burst_next = (state_s == BURST);

   // State register; outputs are registered decodes of the next state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r   <= IDLE;
         cnt_r     <= {LW{1'b0}};
         job_ready <= 1'b1;
         req       <= 1'b0;
         beat      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state_r   <= state_s;
         cnt_r     <= cnt_s;
         job_ready <= (state_s == IDLE);
         req       <= (state_s == REQ) || (state_s == BURST);
         beat      <= (state_s == BURST);
         done      <= (state_s == DONE);
      end
   end

`ifdef RR_REQ_TIMEOUT_EN
   localparam int            WW        = $clog2(TIMEOUT + 1);
   localparam logic [WW-1:0] WAIT_MAX  = WW'(TIMEOUT);
   localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);
   localparam logic [WW-1:0] WAIT_ONE  = {{(WW-1){1'b0}}, 1'b1};

   logic [WW-1:0] wait_r;
   logic          starve_r;

   // Saturating REQ-cycle counter; starvation flag is sticky until reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wait_r   <= {WW{1'b0}};
         starve_r <= 1'b0;
      end else begin
         if (state_s == REQ && state_r != REQ)
            wait_r <= {WW{1'b0}};
         else if (state_r == REQ && wait_r != WAIT_MAX)
            wait_r <= wait_r + WAIT_ONE;
         else
            wait_r <= wait_r;
         if (state_r == REQ && wait_r == WAIT_LAST)
            starve_r <= 1'b1;
         else
            starve_r <= starve_r;
      end
   end

   assign starve = starve_r;
`else
   assign starve = 1'b0;
`endif

endmodule

// File: rtl/rr_req_client_ctrl.sv
// N-client requester front end for the round-robin arbiter: per-client FSMs,
// sticky protocol error and owner encoder. Optional starvation flags: RR_REQ_TIMEOUT_EN.
module rr_req_client_ctrl
   import rr_req_pkg::*;
#(
   parameter int N       = N_DEF,
   parameter int LW      = LW_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N-1:0]         job_valid,
   input  logic [N*LW-1:0]      job_len,
   output logic [N-1:0]         job_ready,
   output logic [N-1:0]         req,
   input  logic [N-1:0]         gnt,
   output logic [N-1:0]         beat,
   output logic [N-1:0]         done,
   output logic                 own_valid,
   output logic [$clog2(N)-1:0] own_id,
   output logic                 err,
   output logic [N-1:0]         starve
);

   localparam int IW = $clog2(N);

   logic [N-1:0]  burst_next_s;
   logic [N-1:0]  prot_err_s;
   logic          err_event_s;
   logic          own_valid_s;
   logic [IW-1:0] own_id_s;

   for (genvar i = 0; i < N; i++) begin : g_client
      rr_req_client #(
         .LW(LW)
`ifdef RR_REQ_TIMEOUT_EN
         , .TIMEOUT(TIMEOUT)
`endif
      ) u_client (
         .clk       (clk),
         .rst       (rst),
         .job_valid (job_valid[i]),
         .job_len   (job_len[i*LW +: LW]),
         .gnt       (gnt[i]),
         .job_ready (job_ready[i]),
         .req       (req[i]),
         .beat      (beat[i]),
         .done      (done[i]),
         .burst_next(burst_next_s[i]),
         .prot_err  (prot_err_s[i]),
         .starve    (starve[i])
      );
   end

   // Protocol error sources and lowest-index owner of the next cycle.
   always_comb begin
      err_event_s = (|prot_err_s) | ~onehot0(32'(gnt));
      own_valid_s = |burst_next_s;
      own_id_s    = {IW{1'b0}};
      for (int i = N - 1; i >= 0; i--) begin
         if (burst_next_s[i]) own_id_s = IW'(i);
         else                 own_id_s = own_id_s;
      end
   end

   // Sticky error and registered ownership report.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err       <= 1'b0;
         own_valid <= 1'b0;
         own_id    <= {IW{1'b0}};
      end else begin
         err       <= err | err_event_s;
         own_valid <= own_valid_s;
         own_id    <= own_id_s;
      end
   end

endmodule

// File: tb/tb_rr_req_client_ctrl.sv
// Randomised and directed bench for rr_req_client_ctrl against a timestamp-based
// reference model; starvation expectations follow RR_REQ_TIMEOUT_EN.
module tb_rr_req_client_ctrl;

   localparam int TIMEOUT = 15;

   logic        clk;
   logic        rst;
   logic [3:0]  job_valid;
   logic [15:0] job_len;
   logic [3:0]  job_ready, req, gnt, beat, done, starve;
   logic        own_valid;
   logic [1:0]  own_id;
   logic        err;

   // arbiter model state and test overrides
   bit          arb_en;
   logic [3:0]  kill, force_gnt, arb_gnt;
   int          pick, own_idx, ptr;
   bit          own_ok;

   // reference model: timestamps per client
   bit          pend [4];
   bit          ownb [4];
   int          gedge[4], lenq[4], endd[4], rstart[4];
   bit          m_err;
   logic [3:0]  m_starve;
   int          e;

   int          n_cmp, n_bad;
   int          beat_cnt[4], done_cnt[4], overlap;

   rr_req_client_ctrl #(.N(4), .LW(4), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst), .job_valid(job_valid), .job_len(job_len),
      .job_ready(job_ready), .req(req), .gnt(gnt), .beat(beat), .done(done),
      .own_valid(own_valid), .own_id(own_id), .err(err), .starve(starve)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Round-robin arbiter: holds the owner while it requests, else rotates from ptr.
   always_comb begin
      pick = -1;
      if (own_ok && req[own_idx]) begin
         pick = own_idx;
      end else begin
         for (int k = 1; k <= 4; k++)
            if (pick < 0 && req[(ptr + k) % 4]) pick = (ptr + k) % 4;
      end
      arb_gnt = (pick >= 0) ? (4'b0001 << pick) : 4'b0000;
      gnt     = arb_en ? (arb_gnt & ~kill) : force_gnt;
   end

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         own_ok  <= 1'b0;
         own_idx <= 0;
         ptr     <= 3;
      end else begin
         own_ok <= (pick >= 0);
         if (pick >= 0) begin
            own_idx <= pick;
            ptr     <= pick;
         end
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp, e);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) begin
         pend[i] = 1'b0;
         ownb[i] = 1'b0;
         endd[i] = -10;
      end
      m_err    = 1'b0;
      m_starve = 4'b0000;
   endtask

   task automatic clear_counts();
      for (int i = 0; i < 4; i++) begin
         beat_cnt[i] = 0;
         done_cnt[i] = 0;
      end
      overlap = 0;
   endtask

   // One clock edge of the specification's rules, using sampled inputs.
   task automatic model_update(input logic [3:0] jv, input logic [15:0] lens, input logic [3:0] g);
      e++;
      if ($countones(g) > 1) m_err = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (pend[i] && (e - rstart[i]) >= TIMEOUT) m_starve[i] = 1'b1;
         if (pend[i]) begin
            if (g[i]) begin
               pend[i]  = 1'b0;
               ownb[i]  = 1'b1;
               gedge[i] = e;
            end
         end else if (ownb[i]) begin
            if (!g[i]) begin
               m_err   = 1'b1;
               ownb[i] = 1'b0;
               endd[i] = e;
            end else if (e - gedge[i] == lenq[i]) begin
               ownb[i] = 1'b0;
               endd[i] = e;
            end
         end else begin
            if (g[i]) m_err = 1'b1;
            if (endd[i] != e - 1 && jv[i]) begin
               pend[i]   = 1'b1;
               rstart[i] = e;
               lenq[i]   = (lens[i*4 +: 4] == 4'd0) ? 1 : int'(lens[i*4 +: 4]);
            end
         end
      end
   endtask

   task automatic check_all();
      logic [3:0] xr, xb, xd, xj, xs;
      logic       xov;
      logic [1:0] xid;
      xov = 1'b0;
      xid = 2'd0;
      for (int i = 0; i < 4; i++) begin
         xr[i] = pend[i] | ownb[i];
         xb[i] = ownb[i];
         xd[i] = (endd[i] == e);
         xj[i] = !(xr[i] | xd[i]);
      end
      for (int i = 3; i >= 0; i--)
         if (ownb[i]) begin
            xov = 1'b1;
            xid = 2'(i);
         end
`ifdef RR_REQ_TIMEOUT_EN
      xs = m_starve;
`else
      xs = 4'b0000;
`endif
      check_eq("req", req, xr);
      check_eq("beat", beat, xb);
      check_eq("done", done, xd);
      check_eq("job_ready", job_ready, xj);
      check_eq("own_valid", own_valid, xov);
      check_eq("own_id", own_id, xid);
      check_eq("err", err, m_err);
      check_eq("starve", starve, xs);
      for (int i = 0; i < 4; i++) begin
         beat_cnt[i] += int'(beat[i]);
         done_cnt[i] += int'(done[i]);
      end
      if ($countones(beat) > 1) overlap++;
   endtask

   // Called at a falling edge: drive, sample just before the rising edge, check after.
   task automatic tick(input logic [3:0] jv, input logic [15:0] lens);
      logic [3:0]  jv_s, g_s;
      logic [15:0] l_s;
      job_valid = jv;
      job_len   = lens;
      #4;
      jv_s = job_valid;
      g_s  = gnt;
      l_s  = job_len;
      @(posedge clk);
      if (rst) model_update(jv_s, l_s, g_s);
      @(negedge clk);
      check_all();
      job_valid = 4'b0000;
   endtask

   task automatic do_reset();
      rst       = 1'b0;
      job_valid = 4'b0000;
      kill      = 4'b0000;
      @(negedge clk);
      rst = 1'b1;
      model_reset();
   endtask

   initial begin
      n_cmp = 0; n_bad = 0; e = 0;
      arb_en = 1'b1; kill = 4'b0000; force_gnt = 4'b0000;
      job_valid = 4'b0000; job_len = 16'h0000;
      model_reset();
      clear_counts();
      rst = 1'b1;
      #1 rst = 1'b0;
      #1;
      check_eq("rst_req", req, 4'b0000);
      check_eq("rst_beat", beat, 4'b0000);
      check_eq("rst_ready", job_ready, 4'b1111);
      check_eq("rst_err", err, 1'b0);
      @(negedge clk);
      rst = 1'b1;

      // single job on client 3
      clear_counts();
      tick(4'b1000, 16'h3000);
      check_eq("single_req", req, 4'b1000);
      for (int c = 0; c < 8; c++) begin
         tick(4'b0000, 16'h0000);
         if (beat[3]) check_eq("single_own_id", own_id, 2'd3);
      end
      check_eq("single_beats", beat_cnt[3], 3);
      check_eq("single_done", done_cnt[3], 1);
      check_eq("single_req_end", req, 4'b0000);

      // contention among clients 1..3, then a zero-length job
      clear_counts();
      tick(4'b1110, 16'h2220);
      for (int c = 0; c < 14; c++) tick(4'b0000, 16'h0000);
      for (int i = 1; i < 4; i++) begin
         check_eq("cont_beats", beat_cnt[i], 2);
         check_eq("cont_done", done_cnt[i], 1);
      end
      check_eq("cont_overlap", overlap, 0);
      check_eq("cont_err", err, 1'b0);
      clear_counts();
      tick(4'b0001, 16'h0000);
      for (int c = 0; c < 5; c++) tick(4'b0000, 16'h0000);
      check_eq("len0_beats", beat_cnt[0], 1);

      // reset asserted mid-burst
      tick(4'b0001, 16'h0005);
      for (int c = 0; c < 10; c++) begin
         if (ownb[0] && e - gedge[0] == 2) break;
         tick(4'b0000, 16'h0000);
      end
      check_eq("mid_burst_reached", (ownb[0] && e - gedge[0] == 2), 1'b1);
      #2 rst = 1'b0;
      #1;
      check_eq("mid_rst_req", req, 4'b0000);
      check_eq("mid_rst_beat", beat, 4'b0000);
      check_eq("mid_rst_done", done, 4'b0000);
      check_eq("mid_rst_own", {own_valid, own_id}, 3'b000);
      check_eq("mid_rst_ready", job_ready, 4'b1111);
      @(negedge clk);
      rst = 1'b1;
      model_reset();
      tick(4'b0000, 16'h0000);
      check_eq("post_rst_ready", job_ready, 4'b1111);

      // randomised traffic through the arbiter model
      clear_counts();
      for (int c = 0; c < 400; c++)
         tick(4'($urandom & $urandom), 16'($urandom));
      check_eq("rand_overlap", overlap, 0);

      // grant withdrawn after two beats
      do_reset();
      clear_counts();
      tick(4'b0010, 16'h0040);
      for (int c = 0; c < 10; c++) begin
         if (ownb[1] && e - gedge[1] == 1) break;
         tick(4'b0000, 16'h0000);
      end
      check_eq("loss_reached", (ownb[1] && e - gedge[1] == 1), 1'b1);
      kill = 4'b0010;
      tick(4'b0000, 16'h0000);
      kill = 4'b0000;
      for (int c = 0; c < 4; c++) tick(4'b0000, 16'h0000);
      check_eq("loss_err", err, 1'b1);
      check_eq("loss_beats", beat_cnt[1], 2);
      check_eq("loss_done", done_cnt[1], 1);
      check_eq("loss_ready", job_ready[1], 1'b1);

      // spurious grant to an idle client
      do_reset();
      arb_en = 1'b0;
      force_gnt = 4'b0100;
      tick(4'b0000, 16'h0000);
      force_gnt = 4'b0000;
      tick(4'b0000, 16'h0000);
      check_eq("spurious_err", err, 1'b1);

      // multi-hot grant with clients 1 and 2 requesting
      do_reset();
      tick(4'b0110, 16'h0110);
      check_eq("mh_pre_err", err, 1'b0);
      force_gnt = 4'b0110;
      tick(4'b0000, 16'h0000);
      check_eq("mh_err", err, 1'b1);
      force_gnt = 4'b0000;
      for (int c = 0; c < 4; c++) tick(4'b0000, 16'h0000);

      // request left ungranted for 20 cycles
      do_reset();
      tick(4'b0001, 16'h0001);
      for (int c = 0; c < 20; c++) tick(4'b0000, 16'h0000);
      check_eq("to_req", req[0], 1'b1);
`ifdef RR_REQ_TIMEOUT_EN
      check_eq("to_starve", starve, 4'b0001);
`else
      check_eq("to_starve", starve, 4'b0000);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
